// File: rtl/eq_pkg.sv
// Shared constants and FSM encoding for the EQ band recompute scheduler.
package eq_pkg;
  localparam int DEF_LOGFFTSIZE = 10;
  localparam int DEF_AUDIOWIDTH = 16;
  localparam int DEF_NBANDS     = 4;
  localparam int WAIT_LO_LIMIT  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } sched_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set-bit finder: lowest set bit of mask at or above start, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [LW-1:0] start_i,
  output logic [LW-1:0] idx_o,
  output logic          found_o
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] sh;
  int             p;

  always_comb begin
    dbl     = {mask_i, mask_i};
    sh      = '0;
    p       = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      p  = int'(start_i) + i;
      sh = dbl >> p;
      if (p >= N) p = p - N;
      if (!found_o && sh[0]) begin
        found_o = 1'b1;
        idx_o   = LW'(p);
      end
    end
  end
endmodule

// File: rtl/eq_band_sched.sv
// Stores per-band EQ settings and launches the gain-curve recompute engine once per
// changed band, round-robin, only while the FFT stage is not reading the curve.
module eq_band_sched
  import eq_pkg::*;
#(
  parameter int LOGFFTSIZE = DEF_LOGFFTSIZE,
  parameter int AUDIOWIDTH = DEF_AUDIOWIDTH,
  parameter int NBANDS     = DEF_NBANDS,
  parameter int LOGNBANDS  = 2,
  parameter int TMO_LOG    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LOGNBANDS-1:0]  cfg_band,
  input  logic [LOGFFTSIZE-1:0] cfg_num,
  input  logic [LOGFFTSIZE-2:0] cfg_width,
  input  logic [AUDIOWIDTH-1:0] cfg_gain,
  input  logic                  curve_lock,
  output logic                  do_recompute,
  output logic [LOGFFTSIZE-1:0] bin_num,
  output logic [LOGFFTSIZE-2:0] bin_width,
  output logic [AUDIOWIDTH-1:0] bin_gain,
  input  logic                  recompute_done,
  output logic [LOGNBANDS-1:0]  active_band,
  output logic                  busy,
  output logic [NBANDS-1:0]     dirty,
  output logic                  err
);
  logic [LOGFFTSIZE-1:0] num_q   [NBANDS];
  logic [LOGFFTSIZE-2:0] width_q [NBANDS];
  logic [AUDIOWIDTH-1:0] gain_q  [NBANDS];

  sched_state_t          state_q;
  logic [NBANDS-1:0]     dirty_q, dirty_d;
  logic [LOGNBANDS-1:0]  rr_q, active_q, pick_idx;
  logic [TMO_LOG-1:0]    cnt_q;
  logic [LOGFFTSIZE-1:0] bin_num_q;
  logic [LOGFFTSIZE-2:0] bin_width_q;
  logic [AUDIOWIDTH-1:0] bin_gain_q;
  logic                  do_q, err_q, ready_q, pick_found, launch, wr_ok;

  rr_pick #(.N(NBANDS), .LW(LOGNBANDS)) u_pick (
    .mask_i  (dirty_q),
    .start_i (rr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign wr_ok  = cfg_valid && (int'(cfg_band) < NBANDS);
  assign launch = (state_q == IDLE) && pick_found && !curve_lock && recompute_done;

  // A write landing on the same edge as the launch clear keeps the band pending.
  always_comb begin
    dirty_d = dirty_q;
    if (launch) dirty_d[pick_idx] = 1'b0;
    if (wr_ok)  dirty_d[cfg_band] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q <= '0;
      for (int i = 0; i < NBANDS; i++) begin
        num_q[i]   <= '0;
        width_q[i] <= '0;
        gain_q[i]  <= '0;
      end
    end else begin
      dirty_q <= dirty_d;
      if (wr_ok) begin
        num_q[cfg_band]   <= cfg_num;
        width_q[cfg_band] <= cfg_width;
        gain_q[cfg_band]  <= cfg_gain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      bin_num_q   <= '0;
      bin_width_q <= '0;
      bin_gain_q  <= '0;
      do_q        <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      do_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            bin_num_q   <= num_q[pick_idx];
            bin_width_q <= width_q[pick_idx];
            bin_gain_q  <= gain_q[pick_idx];
            active_q    <= pick_idx;
            do_q        <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          rr_q    <= (int'(active_q) == NBANDS - 1) ? '0 : active_q + 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!recompute_done) begin
            cnt_q   <= '0;
            state_q <= WAIT_HI;
          end else if (cnt_q == TMO_LOG'(WAIT_LO_LIMIT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_HI: begin
          if (recompute_done) begin
            state_q <= IDLE;
          end else if (&cnt_q) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready    = ready_q;
  assign do_recompute = do_q;
  assign bin_num      = bin_num_q;
  assign bin_width    = bin_width_q;
  assign bin_gain     = bin_gain_q;
  assign active_band  = active_q;
  assign busy         = (state_q != IDLE);
  assign dirty        = dirty_q;
  assign err          = err_q;
endmodule

// File: tb/tb_eq_band_sched.sv
// Bench for eq_band_sched: engine model, launch scoreboard, table-driven writes and corner sequences.
module tb_eq_band_sched;
  localparam int LF = 10;
  localparam int AW = 16;
  localparam int NB = 4;
  localparam int LB = 2;
  localparam int TM = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [LB-1:0] cfg_band = '0;
  logic [LF-1:0] cfg_num = '0;
  logic [LF-2:0] cfg_width = '0;
  logic [AW-1:0] cfg_gain = '0;
  logic          curve_lock = 1'b0;
  logic          do_recompute;
  logic [LF-1:0] bin_num;
  logic [LF-2:0] bin_width;
  logic [AW-1:0] bin_gain;
  logic          recompute_done;
  logic [LB-1:0] active_band;
  logic          busy;
  logic [NB-1:0] dirty;
  logic          err;

  always #5 clk = ~clk;

  eq_band_sched #(.LOGFFTSIZE(LF), .AUDIOWIDTH(AW), .NBANDS(NB), .LOGNBANDS(LB), .TMO_LOG(TM)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_band(cfg_band),
    .cfg_num(cfg_num), .cfg_width(cfg_width), .cfg_gain(cfg_gain), .curve_lock(curve_lock),
    .do_recompute(do_recompute), .bin_num(bin_num), .bin_width(bin_width), .bin_gain(bin_gain),
    .recompute_done(recompute_done), .active_band(active_band), .busy(busy), .dirty(dirty), .err(err)
  );

  // Recompute engine model: done drops the edge after a launch pulse, stays low pass_len cycles.
  int   pass_len = 5;
  bit   never_drop = 1'b0;
  int   eng_cnt = 0;
  logic eng_done = 1'b1;
  assign recompute_done = eng_done;

  always @(posedge clk) begin
    if (do_recompute && !never_drop) begin
      eng_cnt  <= pass_len;
      eng_done <= 1'b0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_done <= 1'b1;
    end
  end

  typedef struct {
    int band;
    int num;
    int width;
    int gain;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   launches = 0;
  bit   prev_do = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every launch pulse is matched against the next expected band record.
  always @(negedge clk) begin
    if (!rst && do_recompute) begin
      rec_t e;
      launches++;
      check("pulse_single_cycle", {31'd0, prev_do}, 32'd0);
      check("launch_engine_idle", {31'd0, recompute_done}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_launch", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_band", 32'(active_band), e.band);
        check("sb_num", 32'(bin_num), e.num);
        check("sb_width", 32'(bin_width), e.width);
        check("sb_gain", 32'(bin_gain), e.gain);
      end
    end
    prev_do = do_recompute;
  end

  task automatic push_exp(input int b, input int n, input int w, input int g);
    rec_t r;
    r.band = b; r.num = n; r.width = w; r.gain = g;
    exp_q.push_back(r);
  endtask

  task automatic cfg_write(input int b, input int n, input int w, input int g);
    cfg_valid = 1'b1;
    cfg_band  = LB'(b);
    cfg_num   = LF'(n);
    cfg_width = (LF-1)'(w);
    cfg_gain  = AW'(g);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_launch(input string name, input int limit);
    int k = 0;
    @(negedge clk);
    while (!do_recompute && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, do_recompute}, 32'd1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    @(negedge clk);
    while (!(busy == 1'b0 && dirty == '0 && exp_q.size() == 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  rec_t t2_tab[3];

  initial begin
    int   saved;
    bit   held_ok;
    int   k;
    logic got;

    t2_tab[0] = '{band: 0, num: 37,  width: 5,   gain: 32'h1111};
    t2_tab[1] = '{band: 1, num: 512, width: 255, gain: 32'h8001};
    t2_tab[2] = '{band: 3, num: 1023, width: 511, gain: 32'hFFFF};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_outputs", {do_recompute, busy, err, dirty, active_band}, 32'd0);
    check("rst_bins", {bin_num, bin_width, bin_gain}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("cfg_ready_after_rst", {31'd0, cfg_ready}, 32'd1);

    // 1: single write, two-cycle config-to-launch latency.
    pass_len = 5;
    push_exp(2, 100, 20, 32'h4000);
    cfg_write(2, 100, 20, 32'h4000);
    @(negedge clk);
    check("t1_no_early_launch", {31'd0, do_recompute}, 32'd0);
    @(negedge clk);
    check("t1_launch", {31'd0, do_recompute}, 32'd1);
    check("t1_bin_num", 32'(bin_num), 32'd100);
    check("t1_bin_width", 32'(bin_width), 32'd20);
    check("t1_bin_gain", 32'(bin_gain), 32'h4000);
    check("t1_active", 32'(active_band), 32'd2);
    check("t1_dirty", 32'(dirty), 32'd0);
    @(negedge clk);
    check("t1_pulse_end", {31'd0, do_recompute}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1_idle", 50);

    // 2: back-to-back writes to three bands, long engine passes, launch order 0,1,3.
    pass_len = 2048;
    for (int i = 0; i < 3; i++) push_exp(t2_tab[i].band, t2_tab[i].num, t2_tab[i].width, t2_tab[i].gain);
    for (int i = 0; i < 3; i++) cfg_write(t2_tab[i].band, t2_tab[i].num, t2_tab[i].width, t2_tab[i].gain);
    wait_idle("t2_idle", 8000);
    check("t2_launch_count", 32'(launches), 32'd4);

    // 3: curve_lock holds off the launch.
    pass_len = 5;
    @(negedge clk);
    curve_lock = 1'b1;
    saved = launches;
    push_exp(1, 64, 8, 32'h0F0F);
    cfg_write(1, 64, 8, 32'h0F0F);
    repeat (6) @(negedge clk);
    check("t3_dirty_locked", 32'(dirty), 32'b0010);
    check("t3_no_launch", 32'(launches), 32'(saved));
    check("t3_not_busy", {31'd0, busy}, 32'd0);
    curve_lock = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 2) begin
      @(negedge clk);
      got = do_recompute;
      k++;
    end
    check("t3_launch_after_unlock", {31'd0, got}, 32'd1);
    wait_idle("t3_idle", 50);

    // 4: rewrite of the active band during WAIT_HI.
    pass_len = 50;
    push_exp(0, 10, 3, 32'h2000);
    push_exp(0, 11, 4, 32'h1000);
    cfg_write(0, 10, 3, 32'h2000);
    wait_launch("t4_launch", 10);
    repeat (5) @(negedge clk);
    cfg_write(0, 11, 4, 32'h1000);
    @(negedge clk);
    check("t4_redirty", 32'(dirty), 32'b0001);
    held_ok = 1'b1;
    k = 0;
    while (!recompute_done && k < 100) begin
      if (bin_gain !== 16'h2000 || bin_num !== 10'd10) held_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check("t4_bins_held", {31'd0, held_ok}, 32'd1);
    wait_idle("t4_idle", 200);

    // 5: engine never acknowledges -> watchdog error 5 cycles after launch.
    never_drop = 1'b1;
    push_exp(2, 300, 7, 32'h0777);
    cfg_write(2, 300, 7, 32'h0777);
    wait_launch("t5_launch", 10);
    repeat (4) @(negedge clk);
    check("t5_err_not_yet", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("t5_err_set", {31'd0, err}, 32'd1);
    check("t5_back_idle", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    check("t5_err_sticky", {31'd0, err}, 32'd1);
    never_drop = 1'b0;

    // 6: reset in WAIT_HI with two bands pending.
    pass_len = 2048;
    push_exp(0, 5, 1, 32'h0123);
    cfg_write(0, 5, 1, 32'h0123);
    wait_launch("t6_launch", 10);
    repeat (5) @(negedge clk);
    cfg_write(1, 6, 2, 32'h0456);
    cfg_write(3, 7, 3, 32'h0789);
    @(negedge clk);
    check("t6_dirty_pending", 32'(dirty), 32'b1010);
    check("t6_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_dirty", 32'(dirty), 32'd0);
    check("t6_rst_err", {31'd0, err}, 32'd0);
    check("t6_rst_bins", {bin_num, bin_width, bin_gain}, 32'd0);
    check("t6_rst_do", {31'd0, do_recompute}, 32'd0);
    repeat (20) @(negedge clk);
    check("t6_stays_idle", {busy, dirty}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/eq_band_sched.md
Name: eq_band_sched

Overview:
- Holds the per-band EQ settings (bin centre, width, gain) entered by the UI and tracks which bands have changed.
- Launches the gain-curve recompute engine once for each changed band, one band at a time.
- Starts a recompute only while the FFT multiply stage is not reading the gain curve.
- Sits between the UI/config logic and the recompute engine. It drives that engine's do_recompute/bin_num/bin_width/bin_gain inputs and watches its recompute_done output.

Parameters:
- LOGFFTSIZE, 10: log2 of FFT size; width of bin index.
- AUDIOWIDTH, 16: width of gain word.
- NBANDS, 4: number of EQ bands (2..16).
- LOGNBANDS, 2: width of band index; ceil(log2(NBANDS)).
- TMO_LOG, 12: log2 of the recompute watchdog limit in cycles; must exceed LOGFFTSIZE+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_valid  in  1  config write strobe.
- cfg_ready  out  1  always 1 after reset; writes are never stalled.
- cfg_band  in  LOGNBANDS  target band.
- cfg_num  in  LOGFFTSIZE  band centre bin.
- cfg_width  in  LOGFFTSIZE-1  band half-width in bins.
- cfg_gain  in  AUDIOWIDTH  band gain.
- curve_lock  in  1  high while the FFT stage reads the gain curve; no launch allowed.
- do_recompute  out  1  one-cycle launch pulse to the recompute engine.
- bin_num  out  LOGFFTSIZE  parameters of the band being recomputed; held stable from launch until return to IDLE.
- bin_width  out  LOGFFTSIZE-1  as bin_num.
- bin_gain  out  AUDIOWIDTH  as bin_num.
- recompute_done  in  1  engine status; high = idle.
- active_band  out  LOGNBANDS  band currently being recomputed.
- busy  out  1  FSM not in IDLE.
- dirty  out  NBANDS  pending-band mask.
- err  out  1  sticky watchdog error; cleared only by rst.

Behaviour:
- Reset values:
  - Outputs: do_recompute=0, bin_num=0, bin_width=0, bin_gain=0, active_band=0, busy=0, dirty=0, err=0. cfg_ready=0 during rst, 1 afterwards.
  - Internal state: all band entries 0; round-robin pointer rr=0; state=IDLE.
  - rst mid-operation aborts immediately. The engine is not signalled and re-arms on its own next do_recompute.
- Config write:
  - On a clk edge with cfg_valid=1 the entry for cfg_band is written and dirty[cfg_band] is set.
  - cfg_band >= NBANDS is ignored.
  - Writes may occur in any state. They never change the bin_* outputs of an in-flight recompute.
- FSM states: IDLE, LAUNCH, WAIT_LO, WAIT_HI.
  - IDLE:
    - If dirty!=0 and curve_lock=0 and recompute_done=1: select band b = first set bit of dirty, searching from rr upward and wrapping.
    - Latch entry b into bin_*, set active_band=b, clear dirty[b], go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH: do_recompute=1 for exactly this cycle; rr <= b+1 mod NBANDS; go to WAIT_LO.
  - WAIT_LO:
    - Wait for recompute_done=0.
    - If it is not seen within 4 cycles of entering WAIT_LO: set err and go to IDLE.
  - WAIT_HI:
    - Wait for recompute_done=1, then go to IDLE.
    - If 2^TMO_LOG cycles elapse first: set err and go to IDLE.
- Latency: a write accepted at edge t into an idle block (lock low, engine idle) gives do_recompute high in the cycle after edge t+1. That is a 2-cycle config-to-launch latency.
- Simultaneous events:
  - A write to band b on the same edge the FSM clears dirty[b]: the set wins, so dirty[b]=1 afterwards. The new values are recomputed later and no update is lost.
  - A write during WAIT_* to active_band re-marks that band dirty; the in-flight pass completes with the old values.
- curve_lock is sampled only in IDLE. Rising during LAUNCH/WAIT_* has no effect.
- A back-to-back write to the same band before launch collapses to one recompute using the last written values.
- busy = (state != IDLE).
- No combinational path from inputs to outputs.

Decomposition:
- Shared package eq_pkg:
  - FSM state encoding (2 bits).
  - Default parameter constants LOGFFTSIZE, AUDIOWIDTH, NBANDS.
  - Constant WAIT_LO_LIMIT=4.
- One natural sub-module, rr_pick: a combinational round-robin first-set-bit finder.
  - Inputs: mask, start pointer.
  - Outputs: index, found.
  - Reusable elsewhere in the design.

Test Plan:
1. Reset, then write band 2 (num=100, width=20, gain=0x4000) with the engine model idle, lock=0 -> do_recompute one-cycle pulse 2 cycles later; bin_num=100, bin_width=20, bin_gain=0x4000, active_band=2; dirty=0000 after launch; busy drops after the model raises done.
2. Write bands 0, 1, 3 in consecutive cycles, with the engine taking 2048 cycles per pass -> launches in order 0, 1, 3; each waits for done; no overlapping do_recompute.
3. Hold curve_lock=1, write band 1 -> no launch, dirty=0010; drop lock -> launch within 2 cycles.
4. During WAIT_HI for band 0, write band 0 with gain=0x1000 -> bin_gain keeps its old value until done; band 0 is relaunched afterwards with 0x1000.
5. Engine model never drops done after do_recompute -> err=1 5 cycles after launch; FSM returns to IDLE; err stays 1 until rst.
6. Assert rst in WAIT_HI with dirty=1010 -> next cycle: busy=0, dirty=0, err=0, bin_*=0, no do_recompute.
